// File: rtl/pong_pkg.sv
// Shared types and default playfield geometry for the pong match controller.
//   match_state_t : match sequencing states
//   LEFT_GOAL_X   : ball x at or below which the right player scores
//   RIGHT_GOAL_X  : ball x at or above which the left player scores
//   H_ACTIVE      : visible pixels per line
//   V_ACTIVE      : visible lines per frame
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } match_state_t;

    localparam int LEFT_GOAL_X  = 90;
    localparam int RIGHT_GOAL_X = 550;
    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;

endpackage

// File: rtl/serve_timer.sv
// Loadable frame-tick down-counter used to hold the ball at the serve position.
//   clk      : pixel clock
//   rst_n    : asynchronous active-low reset
//   load     : load load_val (takes priority over tick)
//   load_val : number of ticks to count
//   tick     : decrement enable (one frame tick)
//   done     : high in the cycle whose tick takes the count from 1 to 0
module serve_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = tick && !load && (count == CNT_W'(1));

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve hold, goal detection, scoring and match end.
//   clk          : pixel clock
//   reset_n      : asynchronous active-low reset
//   frame_tick   : one-cycle pulse per video frame
//   start        : level; a rising edge starts or restarts a match
//   ball_x_pos   : current ball centre x
//   round_rst_n  : low holds ball and paddles at serve position
//   left_score   : left player score (saturating)
//   right_score  : right player score (saturating)
//   point_pulse  : one-cycle pulse per point scored
//   serve_dir    : 1 = next serve toward the right player
//   game_over    : match finished
//   winner       : 0 = left, 1 = right; valid while game_over
//
// state | meaning
// IDLE  | no match yet, scores held at zero, waiting for start edge
// SERVE | ball held, counting frame ticks before release
// PLAY  | ball live, watching both goal lines
// POINT | one cycle to judge whether the last point ended the match
// OVER  | match finished, scores frozen, waiting for start edge
module pong_match_ctrl #(
    parameter int X_W          = 10,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int WIN_BY_TWO   = 0,
    parameter int SERVE_FRAMES = 60,
    parameter int LEFT_GOAL_X  = pong_pkg::LEFT_GOAL_X,
    parameter int RIGHT_GOAL_X = pong_pkg::RIGHT_GOAL_X
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic [X_W-1:0]     ball_x_pos,
    output logic               round_rst_n,
    output logic [SCORE_W-1:0] left_score,
    output logic [SCORE_W-1:0] right_score,
    output logic               point_pulse,
    output logic               serve_dir,
    output logic               game_over,
    output logic               winner
);

    import pong_pkg::*;

    localparam int                 TMR_W      = $clog2(SERVE_FRAMES + 1);
    localparam logic [TMR_W-1:0]   SERVE_LOAD = TMR_W'(SERVE_FRAMES);
    localparam logic [X_W-1:0]     LEFT_X     = X_W'(LEFT_GOAL_X);
    localparam logic [X_W-1:0]     RIGHT_X    = X_W'(RIGHT_GOAL_X);
    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    match_state_t       state, state_nxt;
    logic               start_q;
    logic               start_armed;
    logic               start_edge;
    logic               last_scorer, last_scorer_nxt;
    logic [SCORE_W-1:0] left_nxt, right_nxt;
    logic               round_rst_n_nxt;
    logic               point_pulse_nxt;
    logic               serve_dir_nxt;
    logic               game_over_nxt;
    logic               winner_nxt;
    logic               tmr_load;
    logic               tmr_tick;
    logic               tmr_done;
    logic [SCORE_W:0]   scorer_ext;
    logic [SCORE_W:0]   other_ext;
    logic               win_now;

    // start_armed stays low until start has been seen low, so a start level
    // already high when reset releases is not mistaken for a rising edge.
    assign start_edge = start && !start_q && start_armed;

    assign tmr_tick = frame_tick && (state == ST_SERVE);

    serve_timer #(
        .CNT_W (TMR_W)
    ) u_serve_timer (
        .clk      (clk),
        .rst_n    (reset_n),
        .load     (tmr_load),
        .load_val (SERVE_LOAD),
        .tick     (tmr_tick),
        .done     (tmr_done)
    );

    // Judged in POINT using the scores already updated by the goal.
    assign scorer_ext = last_scorer ? {1'b0, right_score} : {1'b0, left_score};
    assign other_ext  = last_scorer ? {1'b0, left_score}  : {1'b0, right_score};
    assign win_now    = (scorer_ext >= {1'b0, WIN_S}) &&
                        ((WIN_BY_TWO == 0) || (scorer_ext >= other_ext + (SCORE_W+1)'(2)));

    always_comb begin
        state_nxt       = state;
        left_nxt        = left_score;
        right_nxt       = right_score;
        point_pulse_nxt = 1'b0;
        serve_dir_nxt   = serve_dir;
        game_over_nxt   = game_over;
        winner_nxt      = winner;
        last_scorer_nxt = last_scorer;
        tmr_load        = 1'b0;

        case (state)
            ST_IDLE: begin
                left_nxt  = '0;
                right_nxt = '0;
                if (start_edge) begin
                    state_nxt = ST_SERVE;
                    tmr_load  = 1'b1;
                end
            end
            ST_SERVE: begin
                if (tmr_done) begin
                    state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Left goal checked first so it wins if the goal lines overlap.
                if (ball_x_pos <= LEFT_X) begin
                    if (right_score != SCORE_MAX) right_nxt = right_score + 1'b1;
                    serve_dir_nxt   = 1'b0;
                    last_scorer_nxt = 1'b1;
                    point_pulse_nxt = 1'b1;
                    state_nxt       = ST_POINT;
                end else if (ball_x_pos >= RIGHT_X) begin
                    if (left_score != SCORE_MAX) left_nxt = left_score + 1'b1;
                    serve_dir_nxt   = 1'b1;
                    last_scorer_nxt = 1'b0;
                    point_pulse_nxt = 1'b1;
                    state_nxt       = ST_POINT;
                end
            end
            ST_POINT: begin
                if (win_now) begin
                    state_nxt     = ST_OVER;
                    game_over_nxt = 1'b1;
                    winner_nxt    = last_scorer;
                end else begin
                    state_nxt = ST_SERVE;
                    tmr_load  = 1'b1;
                end
            end
            ST_OVER: begin
                if (start_edge) begin
                    left_nxt      = '0;
                    right_nxt     = '0;
                    game_over_nxt = 1'b0;
                    state_nxt     = ST_SERVE;
                    tmr_load      = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        round_rst_n_nxt = (state_nxt == ST_PLAY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            start_q     <= 1'b0;
            start_armed <= 1'b0;
            last_scorer <= 1'b0;
            left_score  <= '0;
            right_score <= '0;
            round_rst_n <= 1'b0;
            point_pulse <= 1'b0;
            serve_dir   <= 1'b1;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            state       <= state_nxt;
            start_q     <= start;
            start_armed <= start_armed || !start;
            last_scorer <= last_scorer_nxt;
            left_score  <= left_nxt;
            right_score <= right_nxt;
            round_rst_n <= round_rst_n_nxt;
            point_pulse <= point_pulse_nxt;
            serve_dir   <= serve_dir_nxt;
            game_over   <= game_over_nxt;
            winner      <= winner_nxt;
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: three instances share one stimulus stream
//   i0: WIN_SCORE=3, first to 3
//   i1: WIN_SCORE=3, must lead by two
//   i2: SCORE_W=2, WIN_SCORE=3, must lead by two (exercises saturation)
// and each is compared every cycle against a rule-level match model.
module tb_pong_match_ctrl;

    localparam int SF  = 3;
    localparam int WS  = 3;
    localparam int LGX = 90;
    localparam int RGX = 550;

    localparam int MD_IDLE  = 0;
    localparam int MD_SERVE = 1;
    localparam int MD_PLAY  = 2;
    localparam int MD_POINT = 3;
    localparam int MD_OVER  = 4;

    logic       clk;
    logic       reset_n;
    logic       frame_tick;
    logic       start;
    logic [9:0] ball_x_pos;

    logic       rr0, pp0, dir0, go0, win0;
    logic       rr1, pp1, dir1, go1, win1;
    logic       rr2, pp2, dir2, go2, win2;
    logic [3:0] l0, r0, l1, r1;
    logic [1:0] l2, r2;

    int n_checks = 0;
    int n_errors = 0;

    // model state per instance
    int m_mode[3], m_ticks[3], m_l[3], m_r[3], m_rr[3], m_pulse[3];
    int m_dir[3], m_over[3], m_win[3], m_scorer[3], m_seen_low[3], m_prev[3];
    int smax[3]  = '{15, 15, 3};
    int wbt[3]   = '{0, 1, 1};

    pong_match_ctrl #(.X_W(10), .SCORE_W(4), .WIN_SCORE(WS), .WIN_BY_TWO(0),
                      .SERVE_FRAMES(SF), .LEFT_GOAL_X(LGX), .RIGHT_GOAL_X(RGX)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
        .ball_x_pos(ball_x_pos), .round_rst_n(rr0), .left_score(l0), .right_score(r0),
        .point_pulse(pp0), .serve_dir(dir0), .game_over(go0), .winner(win0));

    pong_match_ctrl #(.X_W(10), .SCORE_W(4), .WIN_SCORE(WS), .WIN_BY_TWO(1),
                      .SERVE_FRAMES(SF), .LEFT_GOAL_X(LGX), .RIGHT_GOAL_X(RGX)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
        .ball_x_pos(ball_x_pos), .round_rst_n(rr1), .left_score(l1), .right_score(r1),
        .point_pulse(pp1), .serve_dir(dir1), .game_over(go1), .winner(win1));

    pong_match_ctrl #(.X_W(10), .SCORE_W(2), .WIN_SCORE(WS), .WIN_BY_TWO(1),
                      .SERVE_FRAMES(SF), .LEFT_GOAL_X(LGX), .RIGHT_GOAL_X(RGX)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
        .ball_x_pos(ball_x_pos), .round_rst_n(rr2), .left_score(l2), .right_score(r2),
        .point_pulse(pp2), .serve_dir(dir2), .game_over(go2), .winner(win2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            m_mode[m] = MD_IDLE; m_ticks[m] = 0; m_l[m] = 0; m_r[m] = 0;
            m_rr[m] = 0; m_pulse[m] = 0; m_dir[m] = 1; m_over[m] = 0;
            m_win[m] = 0; m_scorer[m] = 0; m_seen_low[m] = 0; m_prev[m] = 0;
        end
    endtask

    task automatic model_step(input int s, input int t, input int x);
        int edge_seen, sc, ot;
        for (int m = 0; m < 3; m++) begin
            edge_seen = (s != 0 && m_prev[m] == 0 && m_seen_low[m] != 0);
            if (s == 0) m_seen_low[m] = 1;
            m_prev[m]  = s;
            m_pulse[m] = 0;
            case (m_mode[m])
                MD_IDLE: begin
                    m_l[m] = 0; m_r[m] = 0;
                    if (edge_seen) begin m_mode[m] = MD_SERVE; m_ticks[m] = SF; end
                end
                MD_SERVE: begin
                    if (t != 0) begin
                        m_ticks[m]--;
                        if (m_ticks[m] == 0) m_mode[m] = MD_PLAY;
                    end
                end
                MD_PLAY: begin
                    if (x <= LGX) begin
                        m_r[m] = (m_r[m] < smax[m]) ? m_r[m] + 1 : smax[m];
                        m_dir[m] = 0; m_scorer[m] = 1; m_pulse[m] = 1; m_mode[m] = MD_POINT;
                    end else if (x >= RGX) begin
                        m_l[m] = (m_l[m] < smax[m]) ? m_l[m] + 1 : smax[m];
                        m_dir[m] = 1; m_scorer[m] = 0; m_pulse[m] = 1; m_mode[m] = MD_POINT;
                    end
                end
                MD_POINT: begin
                    sc = m_scorer[m] ? m_r[m] : m_l[m];
                    ot = m_scorer[m] ? m_l[m] : m_r[m];
                    if (sc >= WS && (wbt[m] == 0 || sc - ot >= 2)) begin
                        m_mode[m] = MD_OVER; m_over[m] = 1; m_win[m] = m_scorer[m];
                    end else begin
                        m_mode[m] = MD_SERVE; m_ticks[m] = SF;
                    end
                end
                default: begin
                    if (edge_seen) begin
                        m_l[m] = 0; m_r[m] = 0; m_over[m] = 0;
                        m_mode[m] = MD_SERVE; m_ticks[m] = SF;
                    end
                end
            endcase
            m_rr[m] = (m_mode[m] == MD_PLAY);
        end
    endtask

    task automatic compare_inst(input string ph, input int m, input logic [31:0] l,
                                input logic [31:0] r, input logic rr, input logic pp,
                                input logic dir, input logic go, input logic win);
        string p;
        p = $sformatf("%s_i%0d", ph, m);
        chk({p, "_left"},  l,   m_l[m]);
        chk({p, "_right"}, r,   m_r[m]);
        chk({p, "_rrst"},  32'(rr),  m_rr[m]);
        chk({p, "_pulse"}, 32'(pp),  m_pulse[m]);
        chk({p, "_dir"},   32'(dir), m_dir[m]);
        chk({p, "_over"},  32'(go),  m_over[m]);
        if (m_over[m] != 0) chk({p, "_winner"}, 32'(win), m_win[m]);
    endtask

    task automatic compare_all(input string ph);
        compare_inst(ph, 0, 32'(l0), 32'(r0), rr0, pp0, dir0, go0, win0);
        compare_inst(ph, 1, 32'(l1), 32'(r1), rr1, pp1, dir1, go1, win1);
        compare_inst(ph, 2, 32'(l2), 32'(r2), rr2, pp2, dir2, go2, win2);
    endtask

    // Called 1 time unit after a posedge; leaves time at 1 after the next posedge.
    task automatic step(input string ph, input logic s, input logic t, input int x);
        start = s; frame_tick = t; ball_x_pos = 10'(x);
        @(posedge clk);
        model_step(int'(s), int'(t), x);
        #1;
        compare_all(ph);
    endtask

    task automatic do_reset(input string ph, input logic s);
        start = s; frame_tick = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all({ph, "_async"});
        @(posedge clk); #1;
        @(posedge clk); #1;
        compare_all({ph, "_held"});
        reset_n = 1'b1;
    endtask

    task automatic serve_until_play(input string ph, input int m);
        for (int i = 0; i < 40 && m_mode[m] != MD_PLAY; i++)
            step(ph, start, (i % 2) == 0, 300);
        case (m)
            0:       chk({ph, "_reach_play"}, 32'(rr0), 1);
            1:       chk({ph, "_reach_play"}, 32'(rr1), 1);
            default: chk({ph, "_reach_play"}, 32'(rr2), 1);
        endcase
    endtask

    initial begin
        logic s_rand;
        int   sel, x;

        reset_n = 1'b0; start = 1'b0; frame_tick = 1'b0; ball_x_pos = 10'd300;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("por");
        reset_n = 1'b1;

        // idle: ticks and goals do nothing
        step("idle", 0, 1, 50);
        step("idle", 0, 0, 600);

        // start pulse then serve of exactly three ticks
        step("start", 1, 0, 300);
        step("start", 0, 0, 300);
        step("serve", 0, 1, 300);
        step("serve", 0, 0, 300);
        step("serve", 0, 1, 300);
        step("serve", 0, 0, 300);
        step("serve2", 1, 0, 300);
        step("serve", 0, 1, 300);
        step("play", 0, 0, 300);

        // right scores at x=85
        step("rgoal", 0, 0, 85);
        step("rgoal", 0, 0, 300);
        step("rgoal", 0, 0, 300);

        // left scores three straight, start rises during play and is held
        serve_until_play("l1", 0); step("l1", 0, 0, 600); step("l1", 0, 0, 300);
        serve_until_play("l2", 0); step("l2", 0, 0, 600); step("l2", 0, 0, 300);
        serve_until_play("l3", 0); step("l3", 1, 0, 600);
        for (int i = 0; i < 6; i++) step("over_hold", 1, i % 2, 600);
        step("restart", 0, 0, 300);
        step("restart", 1, 0, 300);
        step("restart", 0, 0, 300);

        // reach 2-2, then left twice: first-to-3 ends at 3-2, win-by-two at 4-2,
        // 2-bit score saturates at 3
        for (int k = 0; k < 2; k++) begin
            serve_until_play("r22", 0); step("r22", 0, 0, 85); step("r22", 0, 0, 300);
        end
        for (int k = 0; k < 2; k++) begin
            serve_until_play("l22", 0); step("l22", 0, 0, 600); step("l22", 0, 0, 300);
        end
        serve_until_play("l32", 0); step("l32", 0, 0, 600); step("l32", 0, 0, 300);
        serve_until_play("l42", 1); step("l42", 0, 0, 600); step("l42", 0, 0, 300);
        step("l42", 0, 0, 300);

        // restart and abandon a match at 2-1 with an async reset
        step("rs2", 0, 0, 300);
        step("rs2", 1, 0, 300);
        step("rs2", 0, 0, 300);
        serve_until_play("a1", 0); step("a1", 0, 0, 600); step("a1", 0, 0, 300);
        serve_until_play("a2", 0); step("a2", 0, 0, 600); step("a2", 0, 0, 300);
        serve_until_play("a3", 0); step("a3", 0, 0, 85);  step("a3", 0, 0, 300);
        serve_until_play("a4", 0); step("a4", 0, 0, 300);
        do_reset("midplay", 1'b1);
        // start still high after release: no edge until seen low
        for (int i = 0; i < 4; i++) step("post_rst_hi", 1, 1, 300);

        // randomized play
        s_rand = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset("rnd_rst", s_rand);
            end else begin
                if ($urandom_range(0, 14) == 0) s_rand = ~s_rand;
                sel = int'($urandom_range(0, 9));
                case (sel)
                    0: x = int'($urandom_range(0, 90));
                    1: x = int'($urandom_range(550, 639));
                    2: begin
                        case ($urandom_range(0, 3))
                            0: x = 90;
                            1: x = 91;
                            2: x = 549;
                            default: x = 550;
                        endcase
                    end
                    default: x = int'($urandom_range(91, 549));
                endcase
                step("rnd", s_rand, $urandom_range(0, 2) == 0, x);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameter X_W, 10, ball x-coordinate width.
REQ-002 Parameter SCORE_W, 4, score counter width.
REQ-003 Parameter WIN_SCORE, 9, points needed to win; SHALL satisfy 1 <= WIN_SCORE < 2**SCORE_W.
REQ-004 Parameter WIN_BY_TWO, 0, when 1 the winner SHALL also lead by >= 2.
REQ-005 Parameter SERVE_FRAMES, 60, frames held in serve; SHALL be >= 1.
REQ-006 Parameter LEFT_GOAL_X, 90, ball x at or below which right player scores.
REQ-007 Parameter RIGHT_GOAL_X, 550, ball x at or above which left player scores.
REQ-008 clk  in  1  pixel clock; single clock domain.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 frame_tick  in  1  one-cycle pulse per video frame.
REQ-011 start  in  1  synchronous level; rising edge starts/restarts a match.
REQ-012 ball_x_pos  in  X_W  current ball centre x.
REQ-013 round_rst_n  out  1  low holds ball and paddles at serve position.
REQ-014 left_score, right_score  out  SCORE_W each  registered scores.
REQ-015 point_pulse  out  1  one-cycle pulse on every point scored.
REQ-016 serve_dir  out  1  1 = next serve toward right player.
REQ-017 game_over  out  1  match finished; winner  out  1  0 = left, 1 = right, valid while game_over.

Function
REQ-018 FSM states SHALL be IDLE, SERVE, PLAY, POINT, OVER; all outputs registered.
REQ-019 start edge SHALL be detected via a registered copy start_q; a level held high SHALL produce one edge only.
REQ-020 IDLE: round_rst_n=0, scores 0; start edge -> SERVE, serve timer loaded with SERVE_FRAMES.
REQ-021 SERVE: round_rst_n=0; timer decrements on frame_tick; the tick that takes it from 1 to 0 -> PLAY, so PLAY begins exactly SERVE_FRAMES ticks after entry.
REQ-022 PLAY: round_rst_n=1; each cycle, ball_x_pos <= LEFT_GOAL_X -> right_score+1, serve_dir=0; ball_x_pos >= RIGHT_GOAL_X -> left_score+1, serve_dir=1; in that same cycle point_pulse=1, next state POINT.
REQ-023 Both goal conditions true (misconfigured geometry): left goal SHALL take priority.
REQ-024 POINT (one cycle): scorer's score >= WIN_SCORE and (WIN_BY_TWO=0 or lead >= 2) -> OVER with winner=scorer; otherwise -> SERVE with timer reloaded.
REQ-025 Scores SHALL saturate at 2**SCORE_W-1 and never wrap.
REQ-026 OVER: round_rst_n=0, game_over=1, scores frozen; start edge -> scores cleared, game_over=0, -> SERVE.
REQ-027 start edges in SERVE, PLAY, POINT SHALL be ignored.
REQ-028 frame_tick outside SERVE SHALL have no effect.

Reset
REQ-029 reset_n low SHALL asynchronously force: state IDLE, scores 0, round_rst_n 0, point_pulse 0, serve_dir 1, game_over 0, winner 0, timer 0, start_q 0.
REQ-030 Reset asserted mid-SERVE or mid-PLAY SHALL abandon the match; no point is recorded.
REQ-031 After reset release, a start level already high SHALL NOT count as an edge until it has been sampled low.

Structure
REQ-032 Package pong_pkg SHALL hold typedef match_state_t and the default geometry constants (LEFT_GOAL_X, RIGHT_GOAL_X, H_ACTIVE=640, V_ACTIVE=480).
REQ-033 Sub-module serve_timer SHALL implement the loadable frame-tick down-counter with a done output.

Verification (SERVE_FRAMES=3, WIN_SCORE=3 unless stated)
REQ-034 Reset, start pulse, 3 frame_ticks -> round_rst_n rises the cycle after the 3rd tick; no rise after 2 ticks.
REQ-035 In PLAY, drive ball_x_pos=85 -> right_score 0->1, one point_pulse, serve_dir=0, back to SERVE.
REQ-036 Left scores 3 straight points -> game_over=1, winner=0, round_rst_n held 0; further ball_x_pos=600 leaves scores at 3-0.
REQ-037 WIN_BY_TWO=1, score 2-2 then left +1 -> 3-2, no game_over; left +1 -> 4-2, game_over=1, winner=0.
REQ-038 Hold start high across OVER -> no restart; start low then high -> scores 0-0, SERVE entered.
REQ-039 Assert reset_n low during PLAY at 2-1 -> outputs at reset values immediately, with no clk edge required.
